// File: rtl/inner_dot_sched.sv
// Slot sequencer for the shared 9-tap dot-product datapath: arbitrates conv/connect operands,
// tags returning results and folds the three connect partial dots of each pass into one sum.
module inner_dot_sched #(
    parameter int SUM_WIDTH  = 21,
    parameter int CNT_MAX    = 69,
    parameter int CONN_SLOT0 = 34,
    parameter int CONN_SLOT1 = 50,
    parameter int CONN_SLOT2 = 66,
    parameter int DOT_LAT    = 2,
    parameter int PASS_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PASS_W-1:0]            num_pass,
    input  logic                         conv_rdy,
    input  logic                         conn_rdy,
    input  logic signed [SUM_WIDTH-1:0]  dot,
    output logic [$clog2(CNT_MAX)-1:0]   cnt,
    output logic                         in_vld,
    output logic                         conv_ack,
    output logic                         conn_ack,
    output logic                         busy,
    output logic                         done,
    output logic                         res_vld,
    output logic                         res_is_conn,
    output logic [$clog2(CNT_MAX)-1:0]   res_cnt,
    output logic signed [SUM_WIDTH+1:0]  conn_sum,
    output logic                         conn_sum_vld
);

    localparam int CW = $clog2(CNT_MAX);
    localparam int DW = (DOT_LAT > 1) ? $clog2(DOT_LAT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] pass_num;
    logic [DW-1:0]     drain_cnt;
    logic              is_conn;
    logic              issue;
    logic              last_slot;
    logic              last_pass;

    logic [DOT_LAT-1:0] pipe_vld;
    logic [DOT_LAT-1:0] pipe_conn;
    logic [CW-1:0]      pipe_cnt [DOT_LAT];

    logic signed [SUM_WIDTH+1:0] acc;
    logic signed [SUM_WIDTH+1:0] dot_ext;

    always_comb begin
        is_conn   = (cnt == CW'(CONN_SLOT0)) || (cnt == CW'(CONN_SLOT1)) || (cnt == CW'(CONN_SLOT2));
        issue     = (state == RUN) && (is_conn ? conn_rdy : conv_rdy);
        in_vld    = issue;
        conv_ack  = issue && !is_conn;
        conn_ack  = issue && is_conn;
        last_slot = (cnt == CW'(CNT_MAX - 1));
        // pass_num is never 0 once a job runs, so the subtraction cannot wrap
        last_pass = (pass_cnt == PASS_W'(pass_num - PASS_W'(1)));
        busy      = (state != IDLE);
        done      = (state == DRAIN) && (drain_cnt == DW'(DOT_LAT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pass_cnt  <= '0;
            pass_num  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pass_num  <= (num_pass == '0) ? PASS_W'(1) : num_pass;
                        pass_cnt  <= '0;
                        cnt       <= '0;
                        drain_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_slot) begin
                            cnt      <= '0;
                            pass_cnt <= pass_cnt + PASS_W'(1);
                            if (last_pass) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipe matches the datapath latency so each returning dot carries its slot identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld  <= '0;
            pipe_conn <= '0;
            for (int i = 0; i < DOT_LAT; i++) begin
                pipe_cnt[i] <= '0;
            end
        end else begin
            pipe_vld[0]  <= issue;
            pipe_conn[0] <= is_conn;
            pipe_cnt[0]  <= cnt;
            for (int i = 1; i < DOT_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_conn[i] <= pipe_conn[i-1];
                pipe_cnt[i]  <= pipe_cnt[i-1];
            end
        end
    end

    assign res_vld     = pipe_vld[DOT_LAT-1];
    assign res_is_conn = pipe_conn[DOT_LAT-1];
    assign res_cnt     = pipe_cnt[DOT_LAT-1];
    assign dot_ext     = {{2{dot[SUM_WIDTH-1]}}, dot};

    // The first connect slot loads rather than adds, so each pass starts a fresh sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            conn_sum     <= '0;
            conn_sum_vld <= 1'b0;
        end else begin
            conn_sum_vld <= 1'b0;
            if (res_vld && res_is_conn) begin
                if (res_cnt == CW'(CONN_SLOT0)) begin
                    acc <= dot_ext;
                end else begin
                    acc <= acc + dot_ext;
                end
                if (res_cnt == CW'(CONN_SLOT2)) begin
                    conn_sum     <= acc + dot_ext;
                    conn_sum_vld <= 1'b1;
                end
            end
        end
    end

endmodule
